ultrasonic_scheduler: RTL and testbench
=======================================

Name: ultrasonic_scheduler

Overview:
- Time-multiplexes N ultrasonic rangefinders (HC-SR04 style) on the car's single measurement datapath.
- For each sensor slot in round-robin order: issues the trigger pulse, waits for the echo with a timeout, and measures the echo high time directly in centimetres.
- Stores one distance per sensor and enforces a fixed slot period, so consecutive pings never overlap acoustically.
- Sits between the sensor pins and the obstacle-avoidance / motor-control logic.

Parameters:
- N_SENSOR, 3, number of sensors scheduled (left, front, right).
- TRIG_CYC, 480, trigger high width in clk cycles (10 us at 48 MHz).
- CYC_PER_CM, 2824, clk cycles of echo-high time per cm of range (round trip, 48 MHz).
- MAX_CM, 400, saturation and timeout range in cm.
- DW, 9, distance width; must satisfy 2^DW > MAX_CM.
- WAIT_CYC, 1_440_000, maximum cycles from trigger fall to echo rise (30 ms).
- SLOT_CYC, 2_880_000, slot period per sensor (60 ms); must be >= TRIG_CYC + WAIT_CYC + MAX_CM*CYC_PER_CM + 8.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-low reset.
- enable, in, 1, level; 1 = keep scheduling.
- echo_in, in, N_SENSOR, raw echo pins (asynchronous).
- trig_out, out, N_SENSOR, trigger pins.
- dist_cm, out, N_SENSOR*DW, packed per-sensor distance; sensor i occupies bits [i*DW +: DW].
- dist_valid, out, 1, one-cycle pulse when a sensor result is written.
- dist_id, out, $clog2(N_SENSOR), index of the result just written.
- timeout, out, N_SENSOR, per-sensor flag; 1 = last measurement had no echo or saturated.
- busy, out, 1, 1 in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, sel=0, every counter=0, trig_out=0, dist_cm=0, dist_valid=0, dist_id=0, timeout=0, busy=0. Reset mid-ping drops the trigger immediately and discards the partial result.
- Echo path: each echo_in bit passes through a 2-FF synchronizer. Rise/fall are detected on the synchronized signal against its 1-cycle delayed copy. Only the selected sensor's echo is examined.
- States:
  - IDLE: if enable=1, go to TRIG and clear slot_cnt.
  - TRIG: trig_out[sel]=1 for exactly TRIG_CYC cycles, then go to WAIT_RISE. All other trig_out bits stay 0 at all times.
  - WAIT_RISE:
    - Echo already high on entry is ignored; only a rising edge qualifies.
    - Rising edge: clear the cm and prescale counters, go to MEASURE.
    - Wait counter reaches WAIT_CYC: write dist_cm[sel]=MAX_CM, set timeout[sel]=1, go to HOLD.
  - MEASURE:
    - Prescaler counts 0..CYC_PER_CM-1; on wrap, cm counter increments.
    - Falling edge: write dist_cm[sel]=cm count, clear timeout[sel], go to HOLD.
    - cm counter reaching MAX_CM: write MAX_CM, set timeout[sel]=1, go to HOLD.
    - Falling edge and saturation in the same cycle: the saturation rule wins.
  - HOLD: wait until slot_cnt = SLOT_CYC-1. Then sel wraps N_SENSOR-1 to 0. Go to TRIG if enable=1, otherwise IDLE.
- Slot timing: slot_cnt runs from TRIG entry. Slot start spacing is exactly SLOT_CYC cycles while enable stays high.
- Result write: dist_valid=1 and dist_id=sel in the cycle the result register updates. Latency from echo pin fall to dist_valid is 3 or 4 clk cycles.
- enable deasserted mid-slot: the current slot completes, including its result and the full HOLD, then the block goes to IDLE. Re-enable restarts at the next sel.
- Arithmetic: all counters are unsigned and never wrap. The cm counter saturates at MAX_CM.

Decomposition:
- Package ultrasonic_pkg holds:
  - the state enum (IDLE, TRIG, WAIT_RISE, MEASURE, HOLD);
  - the defaults for CYC_PER_CM, MAX_CM, DW and the 48 MHz clock constant;
  - a function computing the SLOT_CYC lower bound, for an elaboration-time assertion.
- Sub-module echo_sync_edge: 2-FF synchronizer plus rise/fall pulse outputs, instantiated once per sensor.

Test Plan (sim params: TRIG_CYC=4, CYC_PER_CM=10, MAX_CM=20, DW=5, WAIT_CYC=50, SLOT_CYC=400, N_SENSOR=3):
- Reset release then enable=1 -> trig_out=3'b001 high for exactly 4 cycles; slot starts for sensor 0, 1, 2 at cycles 0, 400, 800; sel wraps to 0 at 1200.
- Sensor 0 echo high 125 cycles -> dist_cm[0]=12, timeout[0]=0, dist_valid pulses once with dist_id=0, 3-4 cycles after the echo fall.
- Sensor 1 gives no echo -> 50 cycles after trigger fall, dist_cm[1]=20, timeout[1]=1, dist_valid with dist_id=1; next slot still starts at 800.
- Sensor 2 echo held high 500 cycles -> saturates at 20, timeout[2]=1. A later 55-cycle echo on sensor 2 -> 5 cm, timeout[2] cleared.
- Echo already high when WAIT_RISE is entered, falls, then rises 30 cycles later and stays high 40 cycles -> result 4 cm, not 0.
- enable dropped during MEASURE -> result still written, busy stays 1 until cycle 399 of the slot, then IDLE. rst pulsed during TRIG -> trig_out=0 asynchronously and all outputs zero.

Source files
------------

// File: rtl/ultrasonic_pkg.sv
// Shared types and default timing for the ultrasonic rangefinder scheduler.
// Defaults assume a 48 MHz system clock.
package ultrasonic_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT_RISE,
      MEASURE,
      HOLD
   } state_e;

   localparam int unsigned CLK_HZ         = 48_000_000;
   localparam int unsigned DEF_TRIG_CYC   = CLK_HZ / 100_000;
   localparam int unsigned DEF_CYC_PER_CM = 2824;
   localparam int unsigned DEF_MAX_CM     = 400;
   localparam int unsigned DEF_DW         = 9;
   localparam int unsigned DEF_WAIT_CYC   = (CLK_HZ / 1000) * 30;
   localparam int unsigned DEF_SLOT_CYC   = (CLK_HZ / 1000) * 60;

   // Shortest slot that fits trigger, echo wait, a saturated echo and pipeline slack.
   function automatic int unsigned slot_cyc_min(input int unsigned trig_cyc,
                                                input int unsigned wait_cyc,
                                                input int unsigned max_cm,
                                                input int unsigned cyc_per_cm);
      return trig_cyc + wait_cyc + max_cm * cyc_per_cm + 8;
   endfunction

endpackage

// File: rtl/echo_sync_edge.sv
// Two-flop synchronizer for one raw echo pin with rise/fall pulses
// taken from the synchronized level against its one-cycle delayed copy.
module echo_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic echo,
   output logic rise_c,
   output logic fall_c
);

   logic meta;
   logic sync;
   logic sync_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta   <= 1'b0;
         sync   <= 1'b0;
         sync_d <= 1'b0;
      end else begin
         meta   <= echo;
         sync   <= meta;
         sync_d <= sync;
      end
   end

   assign rise_c = sync & ~sync_d;
   assign fall_c = ~sync & sync_d;

endmodule

// File: rtl/ultrasonic_scheduler.sv
// Round-robin scheduler for N HC-SR04 style rangefinders: trigger, wait for
// echo with timeout, measure echo width in cm, hold to a fixed slot period.
module ultrasonic_scheduler
   import ultrasonic_pkg::*;
#(
   parameter int unsigned N_SENSOR   = 3,
   parameter int unsigned TRIG_CYC   = DEF_TRIG_CYC,
   parameter int unsigned CYC_PER_CM = DEF_CYC_PER_CM,
   parameter int unsigned MAX_CM     = DEF_MAX_CM,
   parameter int unsigned DW         = DEF_DW,
   parameter int unsigned WAIT_CYC   = DEF_WAIT_CYC,
   parameter int unsigned SLOT_CYC   = DEF_SLOT_CYC
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic [N_SENSOR-1:0]          echo_in,
   output logic [N_SENSOR-1:0]          trig_out,
   output logic [N_SENSOR*DW-1:0]       dist_cm,
   output logic                         dist_valid,
   output logic [$clog2(N_SENSOR)-1:0]  dist_id,
   output logic [N_SENSOR-1:0]          timeout,
   output logic                         busy
);

   localparam int unsigned IW = $clog2(N_SENSOR);
   localparam int unsigned TW = $clog2(TRIG_CYC + 1);
   localparam int unsigned WW = $clog2(WAIT_CYC + 1);
   localparam int unsigned PW = $clog2(CYC_PER_CM + 1);
   localparam int unsigned SW = $clog2(SLOT_CYC);

   if (SLOT_CYC < slot_cyc_min(TRIG_CYC, WAIT_CYC, MAX_CM, CYC_PER_CM)) begin : g_slot_chk
      $error("SLOT_CYC too short: pings of adjacent slots could overlap");
   end
   if ((1 << DW) <= MAX_CM) begin : g_dw_chk
      $error("DW too narrow to hold MAX_CM");
   end

   state_e               state;
   state_e               state_d;
   logic [IW-1:0]        sel;
   logic [IW-1:0]        sel_d;
   logic [TW-1:0]        trig_cnt;
   logic [WW-1:0]        wait_cnt;
   logic [PW-1:0]        pre_cnt;
   logic [DW-1:0]        cm_cnt;
   logic [SW-1:0]        slot_cnt;
   logic [DW-1:0]        dist_q [N_SENSOR];

   logic [N_SENSOR-1:0]  rise_c;
   logic [N_SENSOR-1:0]  fall_c;
   logic                 pre_wrap_c;
   logic [DW-1:0]        cm_inc_c;
   logic                 wr_c;
   logic                 wr_to_c;
   logic [DW-1:0]        wr_val_c;
   logic [N_SENSOR-1:0]  trig_d_c;

   for (genvar i = 0; i < N_SENSOR; i++) begin : g_sync
      echo_sync_edge u_sync (
         .clk    (clk),
         .rst    (rst),
         .echo   (echo_in[i]),
         .rise_c (rise_c[i]),
         .fall_c (fall_c[i])
      );
      assign dist_cm[i*DW +: DW] = dist_q[i];
   end

   // cm_inc_c includes the current cycle, so a fall reports the full high time
   assign pre_wrap_c = (pre_cnt == PW'(CYC_PER_CM - 1));
   assign cm_inc_c   = pre_wrap_c ? cm_cnt + DW'(1) : cm_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         sel   <= '0;
      end else begin
         state <= state_d;
         sel   <= sel_d;
      end
   end

   always_comb begin
      state_d  = state;
      sel_d    = sel;
      wr_c     = 1'b0;
      wr_to_c  = 1'b0;
      wr_val_c = '0;
      trig_d_c = '0;
      case (state)
         IDLE: begin
            if (enable) state_d = TRIG;
         end
         TRIG: begin
            if (trig_cnt == TW'(TRIG_CYC - 1)) state_d = WAIT_RISE;
         end
         WAIT_RISE: begin
            if (rise_c[sel]) begin
               state_d = MEASURE;
            end else if (wait_cnt == WW'(WAIT_CYC - 1)) begin
               wr_c     = 1'b1;
               wr_to_c  = 1'b1;
               wr_val_c = DW'(MAX_CM);
               state_d  = HOLD;
            end
         end
         MEASURE: begin
            // saturation is checked first so it wins over a coincident fall
            if (cm_inc_c == DW'(MAX_CM)) begin
               wr_c     = 1'b1;
               wr_to_c  = 1'b1;
               wr_val_c = DW'(MAX_CM);
               state_d  = HOLD;
            end else if (fall_c[sel]) begin
               wr_c     = 1'b1;
               wr_val_c = cm_inc_c;
               state_d  = HOLD;
            end
         end
         HOLD: begin
            if (slot_cnt == SW'(SLOT_CYC - 1)) begin
               sel_d   = (sel == IW'(N_SENSOR - 1)) ? '0 : sel + IW'(1);
               state_d = enable ? TRIG : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_d == TRIG) trig_d_c[sel_d] = 1'b1;
   end

   // Phase counters restart whenever their state is (re)entered
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         trig_cnt <= '0;
         wait_cnt <= '0;
         pre_cnt  <= '0;
         cm_cnt   <= '0;
         slot_cnt <= '0;
      end else begin
         trig_cnt <= (state == TRIG && state_d == TRIG) ? trig_cnt + TW'(1) : '0;
         wait_cnt <= (state == WAIT_RISE && state_d == WAIT_RISE) ? wait_cnt + WW'(1) : '0;
         if (state == MEASURE && state_d == MEASURE) begin
            pre_cnt <= pre_wrap_c ? '0 : pre_cnt + PW'(1);
            cm_cnt  <= cm_inc_c;
         end else begin
            pre_cnt <= '0;
            cm_cnt  <= '0;
         end
         if (state_d == IDLE || (state_d == TRIG && state != TRIG)) slot_cnt <= '0;
         else                                                      slot_cnt <= slot_cnt + SW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         trig_out   <= '0;
         busy       <= 1'b0;
         dist_valid <= 1'b0;
         dist_id    <= '0;
         timeout    <= '0;
         for (int i = 0; i < N_SENSOR; i++) dist_q[i] <= '0;
      end else begin
         trig_out   <= trig_d_c;
         busy       <= (state_d != IDLE);
         dist_valid <= wr_c;
         if (wr_c) begin
            dist_q[sel]  <= wr_val_c;
            timeout[sel] <= wr_to_c;
            dist_id      <= sel;
         end
      end
   end

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Directed bench for ultrasonic_scheduler using reduced timing parameters.
module tb_ultrasonic_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic [2:0]  echo_in = 3'b000;
   logic [2:0]  trig_out;
   logic [14:0] dist_cm;
   logic        dist_valid;
   logic [1:0]  dist_id;
   logic [2:0]  timeout;
   logic        busy;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int s_last = 0;

   ultrasonic_scheduler #(
      .N_SENSOR(3), .TRIG_CYC(4), .CYC_PER_CM(10), .MAX_CM(20),
      .DW(5), .WAIT_CYC(50), .SLOT_CYC(400)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .echo_in    (echo_in),
      .trig_out   (trig_out),
      .dist_cm    (dist_cm),
      .dist_valid (dist_valid),
      .dist_id    (dist_id),
      .timeout    (timeout),
      .busy       (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic wait_trig(input logic [2:0] want, input int budget, output int at, output bit ok);
      ok = 1'b0;
      at = -1;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (trig_out === want) begin ok = 1'b1; at = cyc; end
      end
   endtask

   task automatic wait_valid(input int budget, output int at, output bit ok);
      ok = 1'b0;
      at = -1;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (dist_valid === 1'b1) begin ok = 1'b1; at = cyc; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; enable = 1'b0; echo_in = '0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({trig_out, busy, dist_valid} !== 5'b0) begin
         miscompares++; $display("FAIL reset_ctl: got trig=%b busy=%b valid=%b expected all 0", trig_out, busy, dist_valid);
      end
      vectors++;
      if ({dist_cm, dist_id, timeout} !== 20'b0) begin
         miscompares++; $display("FAIL reset_data: got dist=%h id=%0d to=%b expected 0", dist_cm, dist_id, timeout);
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || trig_out !== 3'b000) begin
         miscompares++; $display("FAIL idle_disabled: got busy=%b trig=%b expected 0/000", busy, trig_out);
      end
   endtask

   task automatic test_trigger_and_echo();
      int at, tf, v, width;
      bit ok, only_sel;
      enable = 1'b1;
      wait_trig(3'b001, 10, at, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL slot0_start: got no trigger expected trig=001"); end
      s_last = at;
      width = 1; only_sel = 1'b1;
      do begin
         @(negedge clk);
         if (trig_out !== 3'b000) begin
            width++;
            if (trig_out !== 3'b001) only_sel = 1'b0;
         end
      end while (trig_out !== 3'b000 && width < 20);
      vectors++;
      if (width !== 4) begin miscompares++; $display("FAIL trig_width: got %0d expected 4", width); end
      vectors++;
      if (!only_sel) begin miscompares++; $display("FAIL trig_onehot: got other bits set expected 001"); end
      repeat (5) @(negedge clk);
      echo_in[0] = 1'b1;
      repeat (125) @(negedge clk);
      echo_in[0] = 1'b0;
      tf = cyc;
      wait_valid(10, v, ok);
      vectors++;
      if (!ok || (v - tf) < 3 || (v - tf) > 4) begin
         miscompares++; $display("FAIL s0_latency: got %0d expected 3..4", v - tf);
      end
      vectors++;
      if (dist_id !== 2'd0 || dist_cm[4:0] !== 5'd12 || timeout[0] !== 1'b0) begin
         miscompares++; $display("FAIL s0_result: got id=%0d cm=%0d to=%b expected 0/12/0", dist_id, dist_cm[4:0], timeout[0]);
      end
      @(negedge clk);
      vectors++;
      if (dist_valid !== 1'b0) begin miscompares++; $display("FAIL valid_pulse: got %b expected 0", dist_valid); end
   endtask

   task automatic test_no_echo();
      int at, tf, v;
      bit ok;
      wait_trig(3'b010, 400, at, ok);
      vectors++;
      if (!ok || at - s_last !== 400) begin
         miscompares++; $display("FAIL slot1_start: got %0d expected 400", at - s_last);
      end
      s_last = at;
      wait_trig(3'b000, 10, tf, ok);
      wait_valid(60, v, ok);
      vectors++;
      if (!ok || v - tf !== 50) begin miscompares++; $display("FAIL s1_timeout_time: got %0d expected 50", v - tf); end
      vectors++;
      if (dist_id !== 2'd1 || dist_cm[9:5] !== 5'd20 || timeout[1] !== 1'b1) begin
         miscompares++; $display("FAIL s1_result: got id=%0d cm=%0d to=%b expected 1/20/1", dist_id, dist_cm[9:5], timeout[1]);
      end
   endtask

   task automatic test_saturate_and_wrap();
      int at, tf, w_at;
      bit ok, got_v, got_w;
      logic [1:0] v_id;
      logic [4:0] v_cm;
      logic       v_to;
      logic [2:0] w_trig, prev_trig;
      wait_trig(3'b100, 400, at, ok);
      vectors++;
      if (!ok || at - s_last !== 400) begin
         miscompares++; $display("FAIL slot2_start: got %0d expected 400", at - s_last);
      end
      s_last = at;
      wait_trig(3'b000, 10, tf, ok);
      repeat (5) @(negedge clk);
      echo_in[2] = 1'b1;
      got_v = 1'b0; got_w = 1'b0; prev_trig = trig_out;
      v_id = '0; v_cm = '0; v_to = 1'b0; w_at = -1; w_trig = '0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (dist_valid === 1'b1 && !got_v) begin
            got_v = 1'b1; v_id = dist_id; v_cm = dist_cm[14:10]; v_to = timeout[2];
         end
         if (trig_out !== 3'b000 && prev_trig === 3'b000 && !got_w) begin
            got_w = 1'b1; w_at = cyc; w_trig = trig_out;
         end
         prev_trig = trig_out;
      end
      echo_in[2] = 1'b0;
      vectors++;
      if (!got_v || v_id !== 2'd2 || v_cm !== 5'd20 || v_to !== 1'b1) begin
         miscompares++; $display("FAIL s2_saturate: got seen=%b id=%0d cm=%0d to=%b expected 1/2/20/1", got_v, v_id, v_cm, v_to);
      end
      vectors++;
      if (!got_w || w_at - s_last !== 400 || w_trig !== 3'b001) begin
         miscompares++; $display("FAIL sel_wrap: got dt=%0d trig=%b expected 400/001", w_at - s_last, w_trig);
      end
      s_last = w_at;
   endtask

   task automatic test_short_echo();
      int at, tf, v;
      bit ok;
      wait_trig(3'b100, 1200, at, ok);
      vectors++;
      if (!ok || at - s_last !== 800) begin
         miscompares++; $display("FAIL slot2b_start: got %0d expected 800", at - s_last);
      end
      s_last = at;
      wait_trig(3'b000, 10, tf, ok);
      repeat (5) @(negedge clk);
      echo_in[2] = 1'b1;
      repeat (55) @(negedge clk);
      echo_in[2] = 1'b0;
      wait_valid(10, v, ok);
      vectors++;
      if (!ok || dist_id !== 2'd2 || dist_cm[14:10] !== 5'd5 || timeout[2] !== 1'b0) begin
         miscompares++; $display("FAIL s2_short: got id=%0d cm=%0d to=%b expected 2/5/0", dist_id, dist_cm[14:10], timeout[2]);
      end
   endtask

   task automatic test_echo_high_on_entry();
      int at, tf, v;
      bit ok;
      wait_trig(3'b001, 400, at, ok);
      echo_in[0] = 1'b1;
      s_last = at;
      wait_trig(3'b000, 10, tf, ok);
      repeat (5) @(negedge clk);
      echo_in[0] = 1'b0;
      repeat (30) @(negedge clk);
      echo_in[0] = 1'b1;
      repeat (40) @(negedge clk);
      echo_in[0] = 1'b0;
      wait_valid(10, v, ok);
      vectors++;
      if (!ok || dist_id !== 2'd0 || dist_cm[4:0] !== 5'd4 || timeout[0] !== 1'b0) begin
         miscompares++; $display("FAIL early_high: got seen=%b id=%0d cm=%0d to=%b expected 1/0/4/0", ok, dist_id, dist_cm[4:0], timeout[0]);
      end
   endtask

   task automatic test_enable_drop();
      int at, tf, v;
      bit ok, busy_ok, idle_ok;
      wait_trig(3'b010, 400, at, ok);
      s_last = at;
      wait_trig(3'b000, 10, tf, ok);
      repeat (5) @(negedge clk);
      echo_in[1] = 1'b1;
      repeat (20) @(negedge clk);
      enable = 1'b0;
      repeat (65) @(negedge clk);
      echo_in[1] = 1'b0;
      wait_valid(10, v, ok);
      vectors++;
      if (!ok || dist_id !== 2'd1 || dist_cm[9:5] !== 5'd8 || timeout[1] !== 1'b0) begin
         miscompares++; $display("FAIL drop_result: got seen=%b id=%0d cm=%0d expected 1/1/8", ok, dist_id, dist_cm[9:5]);
      end
      busy_ok = 1'b1;
      for (int i = 0; i < 500 && cyc < s_last + 399; i++) begin
         @(negedge clk);
         if (busy !== 1'b1) busy_ok = 1'b0;
      end
      vectors++;
      if (!busy_ok) begin miscompares++; $display("FAIL drop_busy_hold: got busy low early expected 1 to cycle 399"); end
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL drop_idle: got busy=%b expected 0", busy); end
      idle_ok = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (trig_out !== 3'b000 || busy !== 1'b0) idle_ok = 1'b0;
      end
      vectors++;
      if (!idle_ok) begin miscompares++; $display("FAIL drop_stays_idle: got activity expected none"); end
      enable = 1'b1;
      wait_trig(3'b100, 5, at, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL reenable_sel: got trig=%b expected 100", trig_out); end
   endtask

   task automatic test_reset_mid_trig();
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      vectors++;
      if (trig_out !== 3'b000 || busy !== 1'b0) begin
         miscompares++; $display("FAIL rst_trig: got trig=%b busy=%b expected 000/0", trig_out, busy);
      end
      vectors++;
      if ({dist_cm, dist_valid, dist_id, timeout} !== 21'b0) begin
         miscompares++; $display("FAIL rst_data: got dist=%h id=%0d to=%b expected 0", dist_cm, dist_id, timeout);
      end
      @(negedge clk);
      enable = 1'b0;
      rst = 1'b1;
      repeat (5) @(negedge clk);
      vectors++;
      if (trig_out !== 3'b000 || busy !== 1'b0) begin
         miscompares++; $display("FAIL rst_release_idle: got trig=%b busy=%b expected 000/0", trig_out, busy);
      end
   endtask

   initial begin
      test_reset();
      test_trigger_and_echo();
      test_no_echo();
      test_saturate_and_wrap();
      test_short_echo();
      test_echo_high_on_entry();
      test_enable_drop();
      test_reset_mid_trig();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
